// File: rtl/instr_pkg.sv
// Shared definitions for the matrix-multiply core instruction memory:
// opcode encodings and the loader FSM state type.
package instr_pkg;

    localparam int unsigned OPCODE_WIDTH = 8;

    localparam logic [OPCODE_WIDTH-1:0] LDACI  = 8'd0;
    localparam logic [OPCODE_WIDTH-1:0] LDAC   = 8'd1;
    localparam logic [OPCODE_WIDTH-1:0] LDARR1 = 8'd2;
    localparam logic [OPCODE_WIDTH-1:0] LDARR2 = 8'd3;
    localparam logic [OPCODE_WIDTH-1:0] MVAC   = 8'd4;
    localparam logic [OPCODE_WIDTH-1:0] MVACRi = 8'd5;
    localparam logic [OPCODE_WIDTH-1:0] MVACRj = 8'd6;
    localparam logic [OPCODE_WIDTH-1:0] MVACRk = 8'd7;
    localparam logic [OPCODE_WIDTH-1:0] MVACR1 = 8'd8;
    localparam logic [OPCODE_WIDTH-1:0] MVACR2 = 8'd9;
    localparam logic [OPCODE_WIDTH-1:0] ADDTR  = 8'd10;
    localparam logic [OPCODE_WIDTH-1:0] ADDR1  = 8'd11;
    localparam logic [OPCODE_WIDTH-1:0] ADDR2  = 8'd12;
    localparam logic [OPCODE_WIDTH-1:0] STACI  = 8'd13;
    localparam logic [OPCODE_WIDTH-1:0] STTR   = 8'd14;
    localparam logic [OPCODE_WIDTH-1:0] MULT   = 8'd15;
    localparam logic [OPCODE_WIDTH-1:0] MULTRi = 8'd16;
    localparam logic [OPCODE_WIDTH-1:0] MULTRj = 8'd17;
    localparam logic [OPCODE_WIDTH-1:0] MULTRk = 8'd18;
    localparam logic [OPCODE_WIDTH-1:0] SUB    = 8'd19;
    localparam logic [OPCODE_WIDTH-1:0] SUBRi  = 8'd20;
    localparam logic [OPCODE_WIDTH-1:0] SUBRj  = 8'd21;
    localparam logic [OPCODE_WIDTH-1:0] SUBRk  = 8'd22;
    localparam logic [OPCODE_WIDTH-1:0] CLRR   = 8'd23;
    localparam logic [OPCODE_WIDTH-1:0] CLRAC  = 8'd24;
    localparam logic [OPCODE_WIDTH-1:0] CLRTR  = 8'd25;
    localparam logic [OPCODE_WIDTH-1:0] INAC   = 8'd26;
    localparam logic [OPCODE_WIDTH-1:0] JPNZ   = 8'd27;
    localparam logic [OPCODE_WIDTH-1:0] ENDOP  = 8'd28;
    localparam logic [OPCODE_WIDTH-1:0] LDACRi = 8'd29;
    localparam logic [OPCODE_WIDTH-1:0] LDACRj = 8'd30;
    localparam logic [OPCODE_WIDTH-1:0] LDACRk = 8'd31;
    localparam logic [OPCODE_WIDTH-1:0] LDACR3 = 8'd32;
    localparam logic [OPCODE_WIDTH-1:0] MVACR3 = 8'd33;
    localparam logic [OPCODE_WIDTH-1:0] NOP    = 8'd34;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } loader_state_t;

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: LANES-wide write port and a registered dual read
// returning the word at rd_addr and the one after it (wrapping).
module instr_mem_array #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LANES      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [LANES*DATA_WIDTH-1:0] wr_data,
    input  logic                        rd_en,
    input  logic [ADDR_WIDTH-1:0]       rd_addr,
    output logic [DATA_WIDTH-1:0]       rd_data0,
    output logic [DATA_WIDTH-1:0]       rd_data1
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_addr_next;

    assign rd_addr_next = rd_addr + ADDR_WIDTH'(1);

    // Storage is deliberately not reset so a reset keeps loaded code.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                mem[wr_addr + ADDR_WIDTH'(i)] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data0 <= '0;
            rd_data1 <= '0;
        end else if (rd_en) begin
            rd_data0 <= mem[rd_addr];
            rd_data1 <= mem[rd_addr_next];
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with a streaming valid/ready loader and a fetch port
// that returns opcode plus following operand in one access.
module instr_mem_loader
    import instr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LANES      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_start,
    input  logic                        load_valid,
    input  logic [LANES*DATA_WIDTH-1:0] load_data,
    input  logic                        load_last,
    output logic                        load_ready,
    output logic                        load_done,
    output logic                        load_overflow,
    output logic [ADDR_WIDTH:0]         load_count,
    input  logic                        fetch_req,
    input  logic [ADDR_WIDTH-1:0]       fetch_addr,
    output logic                        fetch_valid,
    output logic [DATA_WIDTH-1:0]       fetch_op,
    output logic [DATA_WIDTH-1:0]       fetch_arg
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned CW    = ADDR_WIDTH + 2;
    localparam logic [CW-1:0] COUNT_CAP = CW'(DEPTH);

    loader_state_t         state, state_next;
    logic [ADDR_WIDTH-1:0] ptr, ptr_next;
    logic                  ready_next, done_next, ovf_next, fvalid_next;
    logic [ADDR_WIDTH:0]   count_next;
    logic [PW-1:0]         ptr_sum;
    logic [CW-1:0]         count_sum;
    logic                  beat_accept, rd_en;

    assign ptr_sum   = {1'b0, ptr} + PW'(LANES);
    assign count_sum = {1'b0, load_count} + CW'(LANES);

    always_comb begin
        state_next  = state;
        ptr_next    = ptr;
        ready_next  = load_ready;
        done_next   = 1'b0;
        ovf_next    = load_overflow;
        count_next  = load_count;
        fvalid_next = 1'b0;
        beat_accept = 1'b0;
        rd_en       = 1'b0;

        // load_start overrides everything, including a same-cycle beat.
        if (load_start) begin
            state_next = ST_LOAD;
            ptr_next   = '0;
            count_next = '0;
            ovf_next   = 1'b0;
            ready_next = 1'b1;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_LOAD: begin
                    if (load_valid && load_ready) begin
                        beat_accept = 1'b1;
                        ptr_next    = ptr_sum[ADDR_WIDTH-1:0];
                        if (ptr_sum[ADDR_WIDTH]) begin
                            ovf_next = 1'b1;
                        end
                        count_next = (count_sum > COUNT_CAP) ? COUNT_CAP[ADDR_WIDTH:0]
                                                             : count_sum[ADDR_WIDTH:0];
                        if (load_last) begin
                            state_next = ST_RUN;
                            ready_next = 1'b0;
                            done_next  = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (fetch_req) begin
                        rd_en       = 1'b1;
                        fvalid_next = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            load_ready    <= 1'b0;
            load_done     <= 1'b0;
            load_overflow <= 1'b0;
            load_count    <= '0;
            fetch_valid   <= 1'b0;
        end else begin
            state         <= state_next;
            ptr           <= ptr_next;
            load_ready    <= ready_next;
            load_done     <= done_next;
            load_overflow <= ovf_next;
            load_count    <= count_next;
            fetch_valid   <= fvalid_next;
        end
    end

    instr_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LANES      (LANES)
    ) u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (beat_accept),
        .wr_addr  (ptr),
        .wr_data  (load_data),
        .rd_en    (rd_en),
        .rd_addr  (fetch_addr),
        .rd_data0 (fetch_op),
        .rd_data1 (fetch_arg)
    );

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: a default-size instance and an
// 8-word instance share stimulus; sel picks which one is being checked.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start, load_valid, load_last, fetch_req;
    logic [15:0] load_data;
    logic [7:0]  fetch_addr;

    logic       b_ready, b_done, b_ovf, b_fvalid;
    logic [8:0] b_count;
    logic [7:0] b_op, b_arg;
    logic       s_ready, s_done, s_ovf, s_fvalid;
    logic [3:0] s_count;
    logic [7:0] s_op, s_arg;

    logic        sel;
    logic        m_ready, m_done, m_ovf, m_fvalid;
    logic [31:0] m_count;
    logic [7:0]  m_op, m_arg;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] op;
        logic [7:0] arg;
        bit         chk_arg;
    } fetch_exp_t;

    fetch_exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_mem_loader dut_big (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(b_ready),
        .load_done(b_done), .load_overflow(b_ovf), .load_count(b_count),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(b_fvalid),
        .fetch_op(b_op), .fetch_arg(b_arg)
    );

    instr_mem_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .LANES(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(s_ready),
        .load_done(s_done), .load_overflow(s_ovf), .load_count(s_count),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr[2:0]), .fetch_valid(s_fvalid),
        .fetch_op(s_op), .fetch_arg(s_arg)
    );

    assign m_ready  = sel ? s_ready  : b_ready;
    assign m_done   = sel ? s_done   : b_done;
    assign m_ovf    = sel ? s_ovf    : b_ovf;
    assign m_fvalid = sel ? s_fvalid : b_fvalid;
    assign m_count  = sel ? 32'(s_count) : 32'(b_count);
    assign m_op     = sel ? s_op  : b_op;
    assign m_arg    = sel ? s_arg : b_arg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic beat(input logic [7:0] l0, input logic [7:0] l1, input logic last);
        load_valid = 1'b1;
        load_data  = {l1, l0};
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = 16'hFFFF;
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [7:0] op,
                            input logic [7:0] arg, input bit chk_arg);
        fetch_exp_t e;
        e.addr = a; e.op = op; e.arg = arg; e.chk_arg = chk_arg;
        exp_q.push_back(e);
    endtask

    task automatic fetch(input logic [7:0] a, input logic [7:0] op, input logic [7:0] arg);
        fetch_req  = 1'b1;
        fetch_addr = a;
        push_exp(a, op, arg, 1'b1);
        tick();
        fetch_req = 1'b0;
        tick();
        chk("fetch_latency", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every presented fetch result must match the oldest request.
    initial begin
        fetch_exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && m_fvalid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL fetch_unexpected: fetch_valid=1 op=%0h arg=%0h, no request pending",
                             m_op, m_arg);
                end else begin
                    e = exp_q.pop_front();
                    if (m_op !== e.op || (e.chk_arg && m_arg !== e.arg)) begin
                        bad++;
                        $display("FAIL fetch_data addr=%0h: got op=%0h arg=%0h want op=%0h arg=%0h",
                                 e.addr, m_op, m_arg, e.op, e.arg);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        sel = 1'b0;
        rst_n = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        load_data = 16'h0; fetch_req = 1'b0; fetch_addr = 8'h0;

        // Reset values
        tick(); tick();
        chk("rst_ready", 32'(m_ready), 32'd0);
        chk("rst_done", 32'(m_done), 32'd0);
        chk("rst_ovf", 32'(m_ovf), 32'd0);
        chk("rst_count", m_count, 32'd0);
        chk("rst_fvalid", 32'(m_fvalid), 32'd0);
        chk("rst_op", 32'(m_op), 32'd0);
        chk("rst_arg", 32'(m_arg), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: three-beat program, default geometry
        start_session();
        chk("t1_ready", 32'(m_ready), 32'd1);
        chk("t1_count0", m_count, 32'd0);
        beat(8'h00, 8'h02, 1'b0);
        chk("t1_ready_b1", 32'(m_ready), 32'd1);
        beat(8'h04, 8'h00, 1'b0);
        chk("t1_done_early", 32'(m_done), 32'd0);
        beat(8'h04, 8'h0F, 1'b1);
        chk("t1_done", 32'(m_done), 32'd1);
        chk("t1_ready_off", 32'(m_ready), 32'd0);
        chk("t1_count", m_count, 32'd6);
        chk("t1_ovf", 32'(m_ovf), 32'd0);
        tick();
        chk("t1_done_pulse", 32'(m_done), 32'd0);
        fetch(8'd0, 8'h00, 8'h02);
        fetch(8'd2, 8'h04, 8'h00);
        fetch(8'd4, 8'h04, 8'h0F);

        // 2: stalled source, then back-to-back fetches
        start_session();
        for (int k = 0; k < 4; k++) begin
            beat(8'(16 + 2*k), 8'(17 + 2*k), k == 3);
            if (k < 3) tick();
        end
        chk("t2_count", m_count, 32'd8);
        chk("t2_done", 32'(m_done), 32'd1);
        for (int i = 0; i < 8; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = 8'(i);
            push_exp(8'(i), 8'(16 + i), 8'(17 + i), i < 7);
            tick();
        end
        fetch_req = 1'b0;
        tick();
        chk("t2_backtoback", 32'(exp_q.size()), 32'd0);

        // 3+4: 8-word instance, wrap, saturation, top-address fetch
        sel = 1'b1;
        start_session();
        beat(8'h01, 8'h02, 1'b0);
        beat(8'h03, 8'h04, 1'b0);
        beat(8'h05, 8'h06, 1'b0);
        chk("t3_count3", m_count, 32'd6);
        chk("t3_ovf3", 32'(m_ovf), 32'd0);
        beat(8'h07, 8'h1B, 1'b0);
        chk("t3_count4", m_count, 32'd8);
        beat(8'h18, 8'h19, 1'b1);
        chk("t3_ovf", 32'(m_ovf), 32'd1);
        chk("t3_count_sat", m_count, 32'd8);
        fetch(8'd7, 8'h1B, 8'h18);
        fetch(8'd0, 8'h18, 8'h19);
        fetch(8'd1, 8'h19, 8'h03);

        // 5: restart colliding with a valid beat mid-session
        start_session();
        for (int k = 0; k < 5; k++) beat(8'(8'h21 + 2*k), 8'(8'h22 + 2*k), 1'b0);
        chk("t5_ovf_pre", 32'(m_ovf), 32'd1);
        chk("t5_count_pre", m_count, 32'd8);
        load_start = 1'b1;
        beat(8'hEE, 8'hEF, 1'b0);
        load_start = 1'b0;
        chk("t5_count_clr", m_count, 32'd0);
        chk("t5_ovf_clr", 32'(m_ovf), 32'd0);
        chk("t5_ready", 32'(m_ready), 32'd1);
        beat(8'hD0, 8'hD1, 1'b1);
        chk("t5_count", m_count, 32'd2);
        fetch(8'd0, 8'hD0, 8'hD1);
        fetch(8'd2, 8'h23, 8'h24);
        fetch(8'd1, 8'hD1, 8'h23);

        // 6: fetch outside RUN, asynchronous reset mid-load
        start_session();
        beat(8'h41, 8'h42, 1'b0);
        fetch_req  = 1'b1;
        fetch_addr = 8'd0;
        tick();
        chk("t6_fvalid_load", 32'(m_fvalid), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", 32'(m_ready), 32'd0);
        chk("t6_rst_count", m_count, 32'd0);
        chk("t6_rst_ovf", 32'(m_ovf), 32'd0);
        chk("t6_rst_fvalid", 32'(m_fvalid), 32'd0);
        chk("t6_rst_op", 32'(m_op), 32'd0);
        chk("t6_rst_arg", 32'(m_arg), 32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("t6_fvalid_idle", 32'(m_fvalid), 32'd0);
        fetch_req = 1'b0;
        start_session();
        beat(8'h51, 8'h52, 1'b1);
        fetch(8'd2, 8'h23, 8'h24);

        tick(); tick();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
